// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR multiply-accumulate sequencer.
package fir_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_MUL = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_ASR = 4'b0101;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_C,
    ST_FETCH_S,
    ST_MUL,
    ST_ACC,
    ST_SHIFT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/fir_mac_seq_if.sv
// Memory read port, shared ALU port and result handshake of the FIR sequencer.
interface fir_mac_seq_if
  import fir_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] alu_flags;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ovf;
  logic              out_ready;

  modport master (
    output mem_rd_en, mem_addr, alu_a, alu_b, alu_ctrl, out_valid, out_data, out_ovf,
    input  mem_rdata, alu_result, alu_flags, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, alu_a, alu_b, alu_ctrl, out_valid, out_data, out_ovf,
    output mem_rdata, alu_result, alu_flags, out_ready
  );
endinterface

// File: rtl/fir_mac_seq.sv
// Computes one FIR output sample by stepping N taps through the shared ALU:
// coefficient fetch, sample fetch, multiply, accumulate, then a final arithmetic shift.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter  int unsigned ADDR_W    = 10,
  parameter  int unsigned BUF_DEPTH = 256,
  parameter  int unsigned MAX_TAPS  = 64,
  localparam int unsigned TAP_W     = $clog2(MAX_TAPS + 1),
  localparam int unsigned HEAD_W    = $clog2(BUF_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [TAP_W-1:0]   ntaps,
  input  logic [ADDR_W-1:0]  coef_base,
  input  logic [ADDR_W-1:0]  samp_base,
  input  logic [HEAD_W-1:0]  head,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  fir_mac_seq_if.master      bus
);

  state_e              state_q, state_d;
  logic [TAP_W-1:0]    ntaps_q, ntaps_d;
  logic [TAP_W-1:0]    k_q, k_d;
  logic [ADDR_W-1:0]   coef_base_q, coef_base_d;
  logic [ADDR_W-1:0]   samp_base_q, samp_base_d;
  logic [HEAD_W-1:0]   head_q, head_d;
  logic [SHAMT_W-1:0]  shamt_q, shamt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   prod_q, prod_d;
  logic                ovf_q, ovf_d;

  logic                busy_q, busy_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_ovf_q, out_ovf_d;

  // Next state and datapath updates, then outputs decoded from the state being entered
  always_comb begin
    state_d     = state_q;
    ntaps_d     = ntaps_q;
    k_d         = k_q;
    coef_base_d = coef_base_q;
    samp_base_d = samp_base_q;
    head_d      = head_q;
    shamt_d     = shamt_q;
    acc_d       = acc_q;
    prod_d      = prod_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ntaps_d     = (ntaps > TAP_W'(MAX_TAPS)) ? TAP_W'(MAX_TAPS) : ntaps;
          coef_base_d = coef_base;
          samp_base_d = samp_base;
          head_d      = head;
          shamt_d     = shamt;
          acc_d       = '0;
          k_d         = '0;
          ovf_d       = 1'b0;
          state_d     = (ntaps == '0) ? ST_SHIFT : ST_FETCH_C;
        end
      end
      ST_FETCH_C: state_d = ST_FETCH_S;
      ST_FETCH_S: state_d = ST_MUL;
      ST_MUL: begin
        prod_d  = bus.alu_result;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_d   = bus.alu_result;
        ovf_d   = ovf_q | bus.alu_flags[FLAG_V];
        k_d     = k_q + TAP_W'(1);
        state_d = ((k_q + TAP_W'(1)) == ntaps_q) ? ST_SHIFT : ST_FETCH_C;
      end
      ST_SHIFT: begin
        out_data_d = bus.alu_result;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      acc_d      = '0;
      out_data_d = out_data_q;
    end

    busy_d      = (state_d != ST_IDLE);
    rd_en_d     = 1'b0;
    addr_d      = '0;
    alu_a_d     = '0;
    alu_b_d     = '0;
    alu_ctrl_d  = ALU_ADD;
    out_valid_d = 1'b0;
    out_ovf_d   = 1'b0;

    unique case (state_d)
      ST_FETCH_C: begin
        rd_en_d = 1'b1;
        addr_d  = coef_base_d + ADDR_W'(k_d);
      end
      ST_FETCH_S: begin
        rd_en_d = 1'b1;
        addr_d  = samp_base_d + ADDR_W'(HEAD_W'(head_d - HEAD_W'(k_d)));
      end
      // Coefficient arrives on the read port as MUL is entered; alu_a holds it
      ST_MUL: begin
        alu_a_d    = bus.mem_rdata;
        alu_ctrl_d = ALU_MUL;
      end
      ST_ACC: begin
        alu_a_d    = acc_d;
        alu_b_d    = prod_d;
        alu_ctrl_d = ALU_ADD;
      end
      ST_SHIFT: begin
        alu_a_d    = acc_d;
        alu_b_d    = DATA_W'(shamt_d);
        alu_ctrl_d = ALU_ASR;
      end
      ST_DONE: begin
        out_valid_d = 1'b1;
        out_ovf_d   = ovf_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ntaps_q     <= '0;
      k_q         <= '0;
      coef_base_q <= '0;
      samp_base_q <= '0;
      head_q      <= '0;
      shamt_q     <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= ALU_ADD;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ntaps_q     <= ntaps_d;
      k_q         <= k_d;
      coef_base_q <= coef_base_d;
      samp_base_q <= samp_base_d;
      head_q      <= head_d;
      shamt_q     <= shamt_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // The sample word only exists on the read port during MUL, so it bypasses the operand register
  assign bus.alu_b     = (state_q == ST_MUL) ? bus.mem_rdata : alu_b_q;
  assign busy          = busy_q;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule
